// File: rtl/demuxf7_q2_pkg.sv
// Shared constants for the demuxf7_q2 stream demultiplexer.
package demuxf7_pkg;

  // Depth of each per-output queue.
  localparam int Q_DEPTH = 2;

  // Route encodings: which output queue a beat is steered to.
  localparam logic ROUTE_O0 = 1'b0;
  localparam logic ROUTE_O1 = 1'b1;

endpackage

// File: rtl/demuxf7_q2_demux_q2.sv
// Two-entry FIFO with head output, used once per output stream.
// Head and tail are held in two explicit registers so the head is
// always directly visible without a read-pointer mux.
module demux_q2 import demuxf7_pkg::*; #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_clr_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic [1:0]       o_count,
  output logic             o_valid
);

  localparam logic [1:0] CNT_MAX = 2'(Q_DEPTH);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [1:0]       r_count;
  logic             w_pop;
  logic             w_push;

  // Qualify requests: never pop an empty queue, never overfill a full one.
  always_comb begin
    w_pop  = i_pop && (r_count != 2'd0);
    w_push = i_push && ((r_count < CNT_MAX) || w_pop);
  end

  // Queue storage and occupancy update.
  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= i_data;
          else                 r_tail <= i_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the incoming beat fills the slot just vacated.
          if (r_count == 2'd1) begin
            r_head <= i_data;
          end else begin
            r_head <= r_tail;
            r_tail <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_head  = r_head;
  assign o_count = r_count;
  assign o_valid = (r_count != 2'd0);

endmodule

// File: rtl/demuxf7_q2.sv
// Registered 1-to-2 stream demultiplexer. Each output owns a 2-entry
// queue; the top level only picks the route, produces IREADY and keeps
// the AUTO-mode alternating phase.
module demuxf7_q2 import demuxf7_pkg::*; #(
  parameter int   WIDTH      = 1,
  parameter logic INIT_PHASE = 1'b0
) (
  input  logic             C,
  input  logic             CLR_N,
  input  logic [WIDTH-1:0] I,
  input  logic             S,
  input  logic             AUTO,
  input  logic             IVALID,
  output logic             IREADY,
  output logic [WIDTH-1:0] O0,
  output logic [WIDTH-1:0] O1,
  output logic             O0VALID,
  output logic             O1VALID,
  input  logic             O0READY,
  input  logic             O1READY,
  output logic             PHASE
);

  localparam logic [1:0] CNT_MAX = 2'(Q_DEPTH);

  logic       r_phase;
  logic       w_route;
  logic [1:0] w_count0;
  logic [1:0] w_count1;
  logic [1:0] w_count_sel;
  logic       w_accept;
  logic       w_push0;
  logic       w_push1;
  logic       w_pop0;
  logic       w_pop1;

  // Route selection and ready: ready depends only on the selected queue's
  // registered occupancy, never on IVALID or the consumers' ready.
  always_comb begin
    w_route     = AUTO ? r_phase : S;
    w_count_sel = (w_route == ROUTE_O1) ? w_count1 : w_count0;
    IREADY      = CLR_N && (w_count_sel < CNT_MAX);
    w_accept    = IVALID && IREADY;
    w_push0     = w_accept && (w_route == ROUTE_O0);
    w_push1     = w_accept && (w_route == ROUTE_O1);
    w_pop0      = O0VALID && O0READY;
    w_pop1      = O1VALID && O1READY;
  end

  // AUTO-mode phase advances once per accepted beat; AUTO=0 freezes it.
  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      r_phase <= INIT_PHASE;
    end else if (w_accept && AUTO) begin
      r_phase <= ~r_phase;
    end
  end

  assign PHASE = r_phase;

  demux_q2 #(.WIDTH(WIDTH)) u_q0 (
    .i_clk   (C),
    .i_clr_n (CLR_N),
    .i_push  (w_push0),
    .i_pop   (w_pop0),
    .i_data  (I),
    .o_head  (O0),
    .o_count (w_count0),
    .o_valid (O0VALID)
  );

  demux_q2 #(.WIDTH(WIDTH)) u_q1 (
    .i_clk   (C),
    .i_clr_n (CLR_N),
    .i_push  (w_push1),
    .i_pop   (w_pop1),
    .i_data  (I),
    .o_head  (O1),
    .o_count (w_count1),
    .o_valid (O1VALID)
  );

endmodule

// File: doc/demuxf7_q2.md
# demuxf7_q2

Registered 1-to-2 stream demultiplexer with ready/valid flow control. It is the inverse of the wide-function 2:1 mux cell: one input stream is steered to one of two output streams. The select comes either from a per-beat S tag or, in AUTO mode, from an internal alternating phase for round-robin deserialisation. It sits between a muxed/serialised source and two independent consumers, and each output has its own 2-entry queue so back-pressure on one consumer never corrupts the other.

## Interface
- WIDTH, 1, data width of I, O0, O1
- INIT_PHASE, 1'b0, PHASE value after reset (AUTO mode starts on this output)

- C  input  1  clock, rising edge
- CLR_N  input  1  asynchronous, active-low reset
- I  input  WIDTH  input data
- S  input  1  per-beat route tag (0 → O0, 1 → O1), used when AUTO=0
- AUTO  input  1  1 = route by PHASE, ignore S
- IVALID  input  1  input beat present
- IREADY  output  1  input beat can be accepted this cycle
- O0, O1  output  WIDTH  head-of-queue data per output
- O0VALID, O1VALID  output  1  queue non-empty
- O0READY, O1READY  input  1  consumer accepts head
- PHASE  output  1  current AUTO-mode route

## Operation
- Route R = AUTO ? PHASE : S, combinational.
- IREADY = CLR_N high AND count[R] < 2. IREADY must not depend on IVALID.
- Accept occurs when IVALID & IREADY at a rising edge: I is written to queue R.
- Pop occurs when OxVALID & OxREADY at a rising edge: the head is discarded and the next entry (if any) becomes head.
- Each queue is a 2-deep FIFO with count 0..2. Ox is the head entry. OxVALID = (count != 0).
- PHASE toggles on every accepted beat while AUTO=1. It holds while AUTO=0 and is never reset by a change of AUTO.
- Same-queue push and pop in one cycle:
  - count 1: count stays 1; the new beat becomes head next cycle.
  - count 2: no push is possible, because IREADY is already low. There is no combinational ready pass-through.
- Push to one queue with a pop from the other in the same cycle: both take effect independently.
- Ox contents when OxVALID=0 are don't-care. The implementation clears them to 0 on reset only.
- Reset (CLR_N low, asynchronous):
  - counts = 0, O0VALID = O1VALID = 0, O0 = O1 = 0
  - PHASE = INIT_PHASE, IREADY = 0
  - Any in-flight beats are dropped.
  - IREADY rises combinationally once CLR_N goes high.

## Timing
- Latency: a beat accepted at edge k is visible on Ox with OxVALID=1 after edge k, i.e. one cycle.
- Throughput: one beat per cycle into a queue whose consumer holds OxREADY=1.
- Full queue: IREADY drops after the edge that makes count[R]=2. It stays low for route R until a pop on that queue.
- IREADY can change within a cycle if S or AUTO changes, because it follows R. The source must hold I/S/IVALID stable until acceptance.
- PHASE updates at the same edge as the accept it counts. The next beat is routed by the new value.
- No combinational path from OxREADY to IREADY, or from IVALID to any output.

## Structure
- Package demuxf7_pkg holds:
  - queue depth constant Q_DEPTH = 2
  - route encodings ROUTE_O0 = 1'b0 and ROUTE_O1 = 1'b1
- Sub-module demux_q2 is a 2-entry FIFO with push/pop/count/head and asynchronous active-low clear, instantiated twice.
- The top level holds only the route select, IREADY logic and the PHASE flop.

## Test plan
- Reset, then AUTO=0: send I=8'hA1 S=0, then 8'hB2 S=1, with both OxREADY=1. Expect O0=A1 and O1=B2, each valid for exactly one cycle, one cycle after its accept.
- AUTO=1, INIT_PHASE=0: stream 1,2,3,4 with S randomised. Expect O0 to get 1,3 and O1 to get 2,4, and PHASE to read 0,1,0,1,0 across accepts.
- O0READY=0, AUTO=0, S=0: push 3 beats. Expect IREADY to fall after the 2nd accept. Release O0READY: the 3rd beat is accepted one cycle later and order is preserved.
- O0 queue full with S=0: switch S=1. Expect IREADY to rise the same cycle and the beat to land in O1, with O0 contents untouched.
- O0 count=1: push and pop in the same cycle for 10 cycles. Expect count to stay 1, O0VALID to stay high, and data to follow the input one cycle late.
- Assert CLR_N mid-stream with both queues full and PHASE=1. Expect all valids 0, IREADY 0 and PHASE=INIT_PHASE immediately (asynchronously). After release, IREADY=1 and no stale data appears.
